decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 84 ++++++++
 rtl/decode_stage_instr_decoder.sv | 128 ++++++++++++
 rtl/decode_stage.sv | 87 ++++++++
 tb/tb_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared ALU op codes, RV32I opcodes, select/kind encodings and the decoded bundle.
// Pure definitions; no latency or flow control of its own.
package decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLL = 4'd2,
        ALU_LT  = 4'd3,
        ALU_LTU = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_OR  = 4'd8,
        ALU_AND = 4'd9,
        ALU_EQ  = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_BRANCH = 3'd1,
        KIND_JAL    = 3'd2,
        KIND_JALR   = 3'd3,
        KIND_LOAD   = 3'd4,
        KIND_STORE  = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        IN1_RS1  = 2'd0,
        IN1_PC   = 2'd1,
        IN1_ZERO = 2'd2
    } in1_sel_e;

    typedef enum logic {
        IN2_RS2 = 1'b0,
        IN2_IMM = 1'b1
    } in2_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        alu_op_e     alu_op;
        in1_sel_e    in1_sel;
        in2_sel_e    in2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        kind_e       kind;
        logic        br_inv;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I decoder: instruction word + pc -> decoded bundle.
// Zero latency, no flow control; unsupported encodings collapse to a harmless illegal bundle.
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output dec_t        o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal;
    alu_op_e    w_rr_op;
    dec_t       w_dec;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    // funct3 map shared by OP and OP-IMM; funct7[5] picks SUB/SRA
    always_comb begin
        w_rr_op = ALU_ADD;
        case (w_f3)
            3'b000:  w_rr_op = w_f7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  w_rr_op = ALU_SLL;
            3'b010:  w_rr_op = ALU_LT;
            3'b011:  w_rr_op = ALU_LTU;
            3'b100:  w_rr_op = ALU_XOR;
            3'b101:  w_rr_op = w_f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_rr_op = ALU_OR;
            default: w_rr_op = ALU_AND;
        endcase
    end

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = i_pc;
        w_dec.rs1     = i_instr[19:15];
        w_dec.rs2     = i_instr[24:20];
        w_dec.rd      = i_instr[11:7];
        w_dec.alu_op  = ALU_ADD;
        w_dec.in1_sel = IN1_RS1;
        w_dec.in2_sel = IN2_RS2;
        w_dec.kind    = KIND_ALU;
        w_legal       = 1'b1;
        case (w_opc)
            OPC_OP: begin
                w_dec.alu_op = w_rr_op;
                w_dec.rd_we  = 1'b1;
                w_legal      = (w_f7 == 7'h00) ||
                               ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                w_dec.alu_op  = (w_f3 == 3'b000) ? ALU_ADD : w_rr_op;
                w_dec.in2_sel = IN2_IMM;
                w_dec.imm     = imm_i(i_instr);
                w_dec.rd_we   = 1'b1;
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == 7'h00);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_dec.in1_sel = (w_opc == OPC_LUI) ? IN1_ZERO : IN1_PC;
                w_dec.in2_sel = IN2_IMM;
                w_dec.imm     = imm_u(i_instr);
                w_dec.rd_we   = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.kind   = KIND_BRANCH;
                w_dec.imm    = imm_b(i_instr);
                w_dec.br_inv = w_f3[0];
                case (w_f3[2:1])
                    2'b00:   w_dec.alu_op = ALU_EQ;
                    2'b10:   w_dec.alu_op = ALU_LT;
                    2'b11:   w_dec.alu_op = ALU_LTU;
                    default: w_legal      = 1'b0;
                endcase
            end
            OPC_JAL: begin
                w_dec.kind    = KIND_JAL;
                w_dec.in1_sel = IN1_PC;
                w_dec.in2_sel = IN2_IMM;
                w_dec.imm     = imm_j(i_instr);
                w_dec.rd_we   = 1'b1;
            end
            OPC_JALR: begin
                w_dec.kind    = KIND_JALR;
                w_dec.in2_sel = IN2_IMM;
                w_dec.imm     = imm_i(i_instr);
                w_dec.rd_we   = 1'b1;
                w_legal       = (w_f3 == 3'b000);
            end
            OPC_LOAD: begin
                w_dec.kind    = KIND_LOAD;
                w_dec.in2_sel = IN2_IMM;
                w_dec.imm     = imm_i(i_instr);
                w_dec.rd_we   = 1'b1;
                w_legal       = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                w_dec.kind    = KIND_STORE;
                w_dec.in2_sel = IN2_IMM;
                w_dec.imm     = imm_s(i_instr);
                w_legal       = !w_f3[2] && (w_f3 != 3'b011);
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            w_dec.alu_op  = ALU_ADD;
            w_dec.in1_sel = IN1_RS1;
            w_dec.in2_sel = IN2_RS2;
            w_dec.imm     = '0;
            w_dec.kind    = KIND_ALU;
            w_dec.br_inv  = 1'b0;
            w_dec.rd_we   = 1'b0;
            w_dec.illegal = 1'b1;
        end
        if (w_dec.rd == 5'd0)
            w_dec.rd_we = 1'b0;
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decoder at the input feeding a 2-entry skid (main + skid register).
// 1-cycle latency; in_ready is the registered "skid empty", so at most two are held under stall.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_alu_op,
    output logic [1:0]  out_in1_sel,
    output logic        out_in2_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [2:0]  out_kind,
    output logic        out_br_inv,
    output logic        out_illegal
);

    dec_t w_dec;
    dec_t r_main;
    dec_t r_skid;
    logic r_main_vld;
    logic r_skid_vld;
    logic w_acc;
    logic w_main_free;

    instr_decoder u_instr_decoder (
        .i_instr (in_instr),
        .i_pc    (in_pc),
        .o_dec   (w_dec)
    );

    assign w_acc       = in_valid & ~r_skid_vld;
    assign w_main_free = ~r_main_vld | out_ready;

    // skid only fills while main is stalled, and in_ready is low whenever it is full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_main_vld <= w_acc;
                if (w_acc)
                    r_main <= w_dec;
            end
        end else if (w_acc) begin
            r_skid     <= w_dec;
            r_skid_vld <= 1'b1;
        end
    end

    assign in_ready    = ~r_skid_vld;
    assign out_valid   = r_main_vld;
    assign out_pc      = r_main.pc;
    assign out_alu_op  = r_main.alu_op;
    assign out_in1_sel = r_main.in1_sel;
    assign out_in2_sel = r_main.in2_sel;
    assign out_imm     = r_main.imm;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd      = r_main.rd;
    assign out_rd_we   = r_main.rd_we;
    assign out_kind    = r_main.kind;
    assign out_br_inv  = r_main.br_inv;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed vectors plus randomized traffic checked against a queue-based reference model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_in1_sel;
    logic        out_in2_sel, out_rd_we, out_br_inv, out_illegal;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_kind;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  in1;
        logic        in2;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we;
        logic [2:0]  kind;
        logic        br_inv;
        logic        illegal;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [31:0] got[$];
    logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23};
    logic [3:0] rr_tab [8] = '{ALU_ADD, ALU_SLL, ALU_LT, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op), .out_in1_sel(out_in1_sel),
        .out_in2_sel(out_in2_sel), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_kind(out_kind), .out_br_inv(out_br_inv),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".pc"},      out_pc,      e.pc);
        chk({tag, ".alu"},     out_alu_op,  e.alu);
        chk({tag, ".in1"},     out_in1_sel, e.in1);
        chk({tag, ".in2"},     out_in2_sel, e.in2);
        chk({tag, ".imm"},     out_imm,     e.imm);
        chk({tag, ".rs1"},     out_rs1,     e.rs1);
        chk({tag, ".rs2"},     out_rs2,     e.rs2);
        chk({tag, ".rd"},      out_rd,      e.rd);
        chk({tag, ".rd_we"},   out_rd_we,   e.rd_we);
        chk({tag, ".kind"},    out_kind,    e.kind);
        chk({tag, ".br_inv"},  out_br_inv,  e.br_inv);
        chk({tag, ".illegal"}, out_illegal, e.illegal);
    endtask

    // Reference decode written from the ISA tables, not from the RTL structure
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1'b1;
        e = '0;
        e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.alu = ALU_ADD;
        case (w[6:0])
            7'h33: begin
                e.alu = rr_tab[f3];
                e.rd_we = 1'b1;
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALU_SRA;
                else if (f7 != 7'h00) ok = 1'b0;
            end
            7'h13: begin
                e.alu = rr_tab[f3];
                e.in2 = 1'b1; e.rd_we = 1'b1;
                e.imm = 32'($signed(w[31:20]));
                if (f3 == 3'd5 && f7 == 7'h20) e.alu = ALU_SRA;
                else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) ok = 1'b0;
            end
            7'h37, 7'h17: begin
                e.in1 = (w[6:0] == 7'h37) ? 2'd2 : 2'd1;
                e.in2 = 1'b1; e.rd_we = 1'b1;
                e.imm = w & 32'hFFFF_F000;
            end
            7'h63: begin
                e.kind = 3'd1;
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
                else begin
                    e.alu = (f3 < 3'd4) ? ALU_EQ : (f3 < 3'd6) ? ALU_LT : ALU_LTU;
                    e.br_inv = f3[0];
                end
            end
            7'h6F: begin
                e.kind = 3'd2; e.in1 = 2'd1; e.in2 = 1'b1; e.rd_we = 1'b1;
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            end
            7'h67: begin
                e.kind = 3'd3; e.in2 = 1'b1; e.rd_we = 1'b1;
                e.imm = 32'($signed(w[31:20]));
                ok = (f3 == 3'd0);
            end
            7'h03: begin
                e.kind = 3'd4; e.in2 = 1'b1; e.rd_we = 1'b1;
                e.imm = 32'($signed(w[31:20]));
                ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                e.kind = 3'd5; e.in2 = 1'b1;
                e.imm = 32'($signed({w[31:25], w[11:7]}));
                ok = (f3 <= 3'd2);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.alu = ALU_ADD; e.in1 = 2'd0; e.in2 = 1'b0; e.imm = '0;
            e.kind = 3'd0; e.br_inv = 1'b0; e.rd_we = 1'b0; e.illegal = 1'b1;
        end
        if (e.rd == 5'd0) e.rd_we = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int pick;
        w = $urandom;
        pick = $urandom_range(0, 9);
        if (pick < 9) begin
            w[6:0] = opcs[pick];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic send1(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1'b1; in_instr = w; in_pc = p; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        bit acc, pop;
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3;
        in_pc = 32'h40; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_pc", out_pc, 0);
        chk("rst.out_imm", out_imm, 0);
        chk("rst.out_rd", out_rd, 0);
        chk("rst.out_rd_we", out_rd_we, 0);
        rst = 1'b0; flush = 1'b0;

        send1(32'h002081B3, 32'h1000);
        chk("add.valid", out_valid, 1);
        chk("add.alu", out_alu_op, ALU_ADD);
        chk("add.rs1", out_rs1, 1);
        chk("add.rs2", out_rs2, 2);
        chk("add.rd", out_rd, 3);
        chk("add.in2", out_in2_sel, 0);
        chk("add.rd_we", out_rd_we, 1);
        chk("add.pc", out_pc, 32'h1000);

        send1(32'h402081B3, 32'h1004);
        chk("sub.alu", out_alu_op, ALU_SUB);
        send1(32'hFFF00093, 32'h1008);
        chk("addi.alu", out_alu_op, ALU_ADD);
        chk("addi.in2", out_in2_sel, 1);
        chk("addi.imm", out_imm, 32'hFFFF_FFFF);
        chk("addi.rd", out_rd, 1);

        send1(32'h0020D463, 32'h100C);
        chk("bge.kind", out_kind, 1);
        chk("bge.alu", out_alu_op, ALU_LT);
        chk("bge.inv", out_br_inv, 1);
        chk("bge.imm", out_imm, 32'h8);
        chk("bge.rd_we", out_rd_we, 0);

        send1(32'h00000000, 32'h1010);
        chk("zero.illegal", out_illegal, 1);
        chk("zero.rd_we", out_rd_we, 0);
        send1(32'h00000013, 32'h1014);
        chk("nop.illegal", out_illegal, 0);
        chk("nop.rd_we", out_rd_we, 0);
        @(posedge clk);
        @(negedge clk);
        chk("drain.valid", out_valid, 0);

        // three back-to-back with consumer stalled for four cycles
        in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h100; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("stall.ir1", in_ready, 1);
        in_pc = 32'h104;
        @(posedge clk); @(negedge clk);
        chk("stall.ir2", in_ready, 0);
        in_pc = 32'h108;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("stall.ir_hold", in_ready, 0);
            chk("stall.head", out_pc, 32'h100);
        end
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            if (out_valid) got.push_back(out_pc);
            acc = in_valid && in_ready;
            @(posedge clk); @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        chk("order.count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("order.pc", got[i], 32'h100 + 4 * i);

        // flush with two held and a pending input
        in_valid = 1'b1; in_pc = 32'h200; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_pc = 32'h204;
        @(posedge clk); @(negedge clk);
        chk("fl2.ir_before", in_ready, 0);
        flush = 1'b1; in_pc = 32'h208;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2.valid", out_valid, 0);
        chk("fl2.ir", in_ready, 1);
        @(posedge clk); @(negedge clk);
        chk("fl2.discard", out_valid, 0);

        // flush beats an input that would otherwise be accepted
        in_valid = 1'b1; in_pc = 32'h300;
        @(posedge clk); @(negedge clk);
        chk("fl1.ir_before", in_ready, 1);
        flush = 1'b1; in_pc = 32'h304;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1.valid", out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("fl1.discard", out_valid, 0);

        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd.out_valid", out_valid, q.size() != 0);
            chk("rnd.in_ready", in_ready, q.size() < 2);
            if (q.size() != 0) chk_out("rnd", q[0]);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            acc = in_valid && (q.size() < 2);
            pop = (q.size() != 0) && out_ready;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(in_instr, in_pc));
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
